// File: rtl/flag_cond_eval_if.sv
// flag_cond_eval_if: groups the ALU flag inputs, the condition req/ack
// handshake, the save/restore stack controls and the status outputs of
// flag_cond_eval into one bundle.
// The master side drives flags and requests (ALU / control unit).
// The slave side is the flag_cond_eval block.
// Optional macro FLAG_STACK_ERR_EN adds the sticky 'err' output.

interface flag_cond_eval_if;

    // ALU flag load
    logic       flag_we;
    logic       c_in;
    logic       n_in;
    logic       z_in;
    logic       v_in;

    // Condition evaluation handshake
    logic       req;
    logic [3:0] cond;
    logic       ack;
    logic       taken;

    // Save/restore stack control and status
    logic       push;
    logic       pop;
    logic [3:0] flags;
    logic       stack_empty;
    logic       stack_full;
`ifdef FLAG_STACK_ERR_EN
    logic       err;
`endif

    modport master (
        output flag_we, c_in, n_in, z_in, v_in,
        output req, cond, push, pop,
        input  ack, taken, flags, stack_empty, stack_full
`ifdef FLAG_STACK_ERR_EN
        , input err
`endif
    );

    modport slave (
        input  flag_we, c_in, n_in, z_in, v_in,
        input  req, cond, push, pop,
        output ack, taken, flags, stack_empty, stack_full
`ifdef FLAG_STACK_ERR_EN
        , output err
`endif
    );

endinterface

// File: rtl/flag_cond_eval.sv
// flag_cond_eval: status-register consumer of the ALU flag path.
//  - Latches {n,z,c,v} from the ALU into a status register.
//  - Evaluates 4-bit condition codes against the *next* status value
//    (so a same-cycle flag load or restore is forwarded) with a fixed
//    one-cycle req -> ack latency and no backpressure.
//  - Keeps a DEPTH-entry LIFO of saved flags for interrupt entry/exit.
// Optional macro FLAG_STACK_ERR_EN: adds a sticky 'err' output that flags
// a push while full or a pop while empty.

module flag_cond_eval #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic            clk,
    input logic            reset,
    flag_cond_eval_if.slave bus
);

    // Pointer constants; the pointer has one extra bit so "full" is
    // distinguishable from "empty" without wrapping.
    localparam logic [PTR_W:0] PTR_ZERO = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0] PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] PTR_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] IDX_ONE = {{(PTR_W - 1){1'b0}}, 1'b1};

    // Condition code decode against a {n,z,c,v} flag vector.
    function automatic logic cond_eval(input logic [3:0] code,
                                       input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (code)
            4'b0000: r = z;                    // EQ
            4'b0001: r = ~z;                   // NE
            4'b0010: r = c;                    // CS
            4'b0011: r = ~c;                   // CC
            4'b0100: r = n;                    // MI
            4'b0101: r = ~n;                   // PL
            4'b0110: r = v;                    // VS
            4'b0111: r = ~v;                   // VC
            4'b1000: r = c & ~z;               // HI
            4'b1001: r = ~c | z;               // LS
            4'b1010: r = ~(n ^ v);             // GE
            4'b1011: r = n ^ v;                // LT
            4'b1100: r = ~z & ~(n ^ v);        // GT
            4'b1101: r = z | (n ^ v);          // LE
            4'b1110: r = 1'b1;                 // AL
            4'b1111: r = 1'b0;                 // NV
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Registered state
    logic [3:0]     flags_q,  flags_d;
    logic [PTR_W:0] ptr_q,    ptr_d;
    logic           ack_q,    ack_d;
    logic           taken_q,  taken_d;
    logic           empty_q,  empty_d;
    logic           full_q,   full_d;
`ifdef FLAG_STACK_ERR_EN
    logic           err_q,    err_d;
`endif

    // Save stack storage (contents are don't-care after reset)
    logic [3:0]       stack_q [DEPTH];
    logic             stack_we;
    logic [PTR_W-1:0] stack_widx;
    logic [PTR_W-1:0] stack_ridx;

    // Decoded stack operations
    logic push_ok;
    logic pop_ok;
    logic push_only;
    logic pop_only;

    // Decode push/pop legality; simultaneous push+pop cancels both.
    always_comb begin
        push_only = bus.push & ~bus.pop;
        pop_only  = bus.pop & ~bus.push;
        push_ok   = push_only & ~full_q;
        pop_ok    = pop_only & ~empty_q;
    end

    // Stack addressing: write at ptr, read the top entry at ptr-1.
    always_comb begin
        stack_widx = ptr_q[PTR_W-1:0];
        stack_ridx = ptr_q[PTR_W-1:0] - IDX_ONE;
        stack_we   = push_ok;
    end

    // Status next value: flag load beats restore, restore beats hold.
    always_comb begin
        flags_d = flags_q;
        if (bus.flag_we) begin
            flags_d = {bus.n_in, bus.z_in, bus.c_in, bus.v_in};
        end else if (pop_ok) begin
            flags_d = stack_q[stack_ridx];
        end else begin
            flags_d = flags_q;
        end
    end

    // Pointer update and registered empty/full derived from the new pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (push_ok) begin
            ptr_d = ptr_q + PTR_ONE;
        end else if (pop_ok) begin
            ptr_d = ptr_q - PTR_ONE;
        end else begin
            ptr_d = ptr_q;
        end
        empty_d = (ptr_d == PTR_ZERO);
        full_d  = (ptr_d == PTR_FULL);
    end

    // Condition evaluation against the forwarded next flags.
    always_comb begin
        ack_d   = 1'b0;
        taken_d = 1'b0;
        if (bus.req) begin
            ack_d   = 1'b1;
            taken_d = cond_eval(bus.cond, flags_d);
        end else begin
            ack_d   = 1'b0;
            taken_d = 1'b0;
        end
    end

`ifdef FLAG_STACK_ERR_EN
    // Sticky error on an illegal lone push (full) or lone pop (empty).
    always_comb begin
        err_d = err_q;
        if ((push_only & full_q) | (pop_only & empty_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end
`endif

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
            ptr_q   <= PTR_ZERO;
            ack_q   <= 1'b0;
            taken_q <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            taken_q <= taken_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

`ifdef FLAG_STACK_ERR_EN
    // Sticky error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Stack storage write; saves the pre-update status value.
    always_ff @(posedge clk) begin
        if (stack_we) begin
            stack_q[stack_widx] <= flags_q;
        end
    end

    // Output drive
    assign bus.flags       = flags_q;
    assign bus.ack         = ack_q;
    assign bus.taken       = taken_q;
    assign bus.stack_empty = empty_q;
    assign bus.stack_full  = full_q;
`ifdef FLAG_STACK_ERR_EN
    assign bus.err         = err_q;
`endif

endmodule
